// File: rtl/fifo_burst_tester.sv
// fifo_burst_tester: push-button burst exerciser for the SRAM-backed FIFO.
//
// Two raw active-low keys are synchronised and debounced; a write press issues
// burst_len+1 write strobes with an incrementing data value, and a read press
// issues burst_len+1 read strobes and captures each returned word. FIFO busy,
// empty and overflow are honoured, and every wait is bounded by TIMEOUT cycles.
//
// Optional feature, macro FIFO_BURST_CHECK_EN: compare each captured word with
// an expected-value counter (loaded with seed on rst) and count mismatches.
// When the macro is undefined, err_cnt and flags[2] are tied to 0.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   key_we_n/key_re_n raw asynchronous active-low write/read keys
//   burst_len         words per burst minus 1, sampled at burst start
//   seed              initial data value, loaded on rst
//   fifo_we/fifo_re   one-cycle write/read strobes to the FIFO
//   fifo_din          write data, valid with fifo_we
//   fifo_dout         read data, valid with fifo_data_r_rdy
//   fifo_data_r_rdy, fifo_busy, fifo_overflow, fifo_empty  FIFO status
//   last_rd_data      last captured read word
//   err_cnt           saturating compare-mismatch count
//   flags             sticky {timeout, mismatch, underrun, overflow}
//   state_dbg         current FSM state encoding
//   done              one-cycle pulse when a burst completes or aborts
module fifo_burst_tester #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SEED_W    = 8,
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 19,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we_n,
  input  logic              key_re_n,
  input  logic [7:0]        burst_len,
  input  logic [SEED_W-1:0] seed,
  output logic              fifo_we,
  output logic              fifo_re,
  output logic [DATA_W-1:0] fifo_din,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_data_r_rdy,
  input  logic              fifo_busy,
  input  logic              fifo_overflow,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] last_rd_data,
  output logic [15:0]       err_cnt,
  output logic [3:0]        flags,
  output logic [3:0]        state_dbg,
  output logic              done
);

  localparam logic [DB_W-1:0] DbMax = DB_W'(DB_CYCLES - 1);
  localparam int unsigned     TmoW  = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StWrIssue = 4'd1,
    StWrWait  = 4'd2,
    StRdIssue = 4'd3,
    StRdWait  = 4'd4,
    StDone    = 4'd5
  } state_e;

  // ---------------------------------------------------------------------------
  // Key synchronisers and debouncers. Bit 0 is the write key, bit 1 the read key.
  // ---------------------------------------------------------------------------
  logic [1:0]           key_sync1_q, key_sync2_q;
  logic [1:0]           key_pressed;
  logic [1:0]           db_q, db_prev_q, press_q;
  logic [1:0][DB_W-1:0] db_cnt_q;

  assign key_pressed = ~key_sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_sync1_q <= 2'b11;
      key_sync2_q <= 2'b11;
      db_q        <= '0;
      db_prev_q   <= '0;
      press_q     <= '0;
      db_cnt_q    <= '0;
    end else begin
      key_sync1_q <= {key_re_n, key_we_n};
      key_sync2_q <= key_sync1_q;
      db_prev_q   <= db_q;
      // Registered rising edge of the debounced level: one cycle per press.
      press_q     <= db_q & ~db_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (key_pressed[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbMax) begin
          db_q[i]     <= key_pressed[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [7:0]        rem_q, rem_d;
  logic [TmoW-1:0]   tmo_q;
  logic              tmo_expired;
  logic [DATA_W-1:0] wr_val_q, wr_val_d;
  logic              we_q, we_d, re_q, re_d;
  logic [DATA_W-1:0] din_q, last_q;
  logic [3:0]        flags_q, flags_d;
  logic              capture;
  logic              mismatch;

  assign tmo_expired = (tmo_q >= TmoW'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wr_val_d = wr_val_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    flags_d  = flags_q;
    capture  = 1'b0;

    case (state_q)
      StIdle: begin
        // Read wins when both presses land in the same cycle.
        if (press_q[1]) begin
          rem_d   = burst_len;
          state_d = StRdIssue;
        end else if (press_q[0]) begin
          rem_d   = burst_len;
          state_d = StWrIssue;
        end
      end
      StWrIssue: begin
        if (fifo_overflow) begin
          flags_d[0] = 1'b1;
          state_d    = StDone;
        end else if (!fifo_busy) begin
          we_d     = 1'b1;
          wr_val_d = wr_val_q + DATA_W'(1);
          state_d  = StWrWait;
        end else if (tmo_expired) begin
          flags_d[3] = 1'b1;
          state_d    = StDone;
        end
      end
      StWrWait: begin
        // First cycle is skipped so the FIFO has time to raise busy.
        if (tmo_q == '0) begin
          state_d = StWrWait;
        end else if (!fifo_busy) begin
          if (rem_q == 8'd0) begin
            state_d = StDone;
          end else begin
            rem_d   = rem_q - 8'd1;
            state_d = StWrIssue;
          end
        end else if (tmo_expired) begin
          flags_d[3] = 1'b1;
          state_d    = StDone;
        end
      end
      StRdIssue: begin
        if (fifo_empty) begin
          flags_d[1] = 1'b1;
          state_d    = StDone;
        end else if (!fifo_busy) begin
          re_d    = 1'b1;
          state_d = StRdWait;
        end else if (tmo_expired) begin
          flags_d[3] = 1'b1;
          state_d    = StDone;
        end
      end
      StRdWait: begin
        if (fifo_data_r_rdy) begin
          capture = 1'b1;
          if (mismatch) flags_d[2] = 1'b1;
          if (rem_q == 8'd0) begin
            state_d = StDone;
          end else begin
            rem_d   = rem_q - 8'd1;
            state_d = StRdIssue;
          end
        end else if (tmo_expired) begin
          flags_d[3] = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      tmo_q    <= '0;
      wr_val_q <= DATA_W'(seed);
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      din_q    <= '0;
      last_q   <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wr_val_q <= wr_val_d;
      we_q     <= we_d;
      re_q     <= re_d;
      flags_q  <= flags_d;
      if (we_d) din_q <= wr_val_q;
      if (capture) last_q <= fifo_dout;
      // Counts cycles spent in the current state; saturates once expired.
      if (state_d != state_q) begin
        tmo_q <= '0;
      end else if (!tmo_expired) begin
        tmo_q <= tmo_q + TmoW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional ordering check
  // ---------------------------------------------------------------------------
`ifdef FIFO_BURST_CHECK_EN
  logic [DATA_W-1:0] exp_val_q;
  logic [15:0]       err_cnt_q;

  assign mismatch = capture && (fifo_dout != exp_val_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_val_q <= DATA_W'(seed);
      err_cnt_q <= '0;
    end else if (capture) begin
      exp_val_q <= exp_val_q + DATA_W'(1);
      if (mismatch && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign mismatch = 1'b0;
  assign err_cnt  = '0;
`endif

  assign fifo_we      = we_q;
  assign fifo_re      = re_q;
  assign fifo_din     = din_q;
  assign last_rd_data = last_q;
  assign flags        = flags_q;
  assign state_dbg    = state_q;
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_fifo_burst_tester.sv
// Scoreboard bench for fifo_burst_tester: a behavioural FIFO answers the
// strobes, a reference model predicts written data, captured data, flags and
// error counts, and a monitor compares at each strobe and done pulse.
module tb_fifo_burst_tester;

  localparam int unsigned DataW    = 8;
  localparam int unsigned DbCycles = 4;

  logic             clk, rst, key_we_n, key_re_n;
  logic [7:0]       burst_len, seed;
  logic             fifo_we, fifo_re, fifo_data_r_rdy, fifo_busy, fifo_overflow, fifo_empty;
  logic [DataW-1:0] fifo_din, fifo_dout, last_rd_data;
  logic [15:0]      err_cnt;
  logic [3:0]       flags, state_dbg;
  logic             done;

  fifo_burst_tester #(
    .DATA_W   (DataW),
    .SEED_W   (8),
    .DB_CYCLES(DbCycles),
    .DB_W     (3),
    .TIMEOUT  (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_we_n       (key_we_n),
    .key_re_n       (key_re_n),
    .burst_len      (burst_len),
    .seed           (seed),
    .fifo_we        (fifo_we),
    .fifo_re        (fifo_re),
    .fifo_din       (fifo_din),
    .fifo_dout      (fifo_dout),
    .fifo_data_r_rdy(fifo_data_r_rdy),
    .fifo_busy      (fifo_busy),
    .fifo_overflow  (fifo_overflow),
    .fifo_empty     (fifo_empty),
    .last_rd_data   (last_rd_data),
    .err_cnt        (err_cnt),
    .flags          (flags),
    .state_dbg      (state_dbg),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  flags;
    logic [15:0] err;
    logic [7:0]  last;
  } done_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_we_q[$];
  done_exp_t   exp_done_q[$];
  done_exp_t   mon_e;
  int          we_cnt = 0, re_cnt = 0, done_cnt = 0;
  bit          prev_strobe = 0;

  // Behavioural FIFO state and fault-injection knobs.
  logic [7:0]  mem[$];
  int          busy_left = 0, rd_wait = 0, rd_total = 0, corrupt_at = -1;
  bit          rd_pend = 0, force_busy = 0, force_empty = 0, force_ovf = 0;
  logic [7:0]  rd_val;

  // Reference model.
  logic [7:0]  ref_wr_val, ref_exp_val, ref_last;
  logic [7:0]  ref_fifo[$];
  logic [15:0] ref_err;
  logic [3:0]  ref_flags;
  int          ref_rd_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: reacts to strobes seen at the falling edge.
  initial begin
    fifo_busy = 0; fifo_empty = 1; fifo_overflow = 0; fifo_data_r_rdy = 0; fifo_dout = '0;
    forever begin
      @(negedge clk);
      fifo_data_r_rdy = 0;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          fifo_data_r_rdy = 1;
          fifo_dout       = rd_val;
          rd_pend         = 0;
        end else begin
          rd_wait--;
        end
      end
      if (fifo_we) begin
        mem.push_back(fifo_din);
        busy_left = $urandom_range(0, 3);
      end
      if (fifo_re) begin
        rd_val = (mem.size() > 0) ? mem.pop_front() : 8'hEE;
        if (rd_total == corrupt_at) rd_val = rd_val ^ 8'h5A;
        rd_total++;
        rd_pend = 1;
        rd_wait = $urandom_range(0, 2);
      end
      fifo_busy = force_busy || (busy_left > 0);
      if (busy_left > 0) busy_left--;
      fifo_empty    = force_empty || (mem.size() == 0);
      fifo_overflow = force_ovf;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or done.
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_we || fifo_re) begin
        check("strobe_overlap_or_back_to_back", {30'd0, fifo_we & fifo_re, prev_strobe}, 32'd0);
      end
      if (fifo_we) begin
        we_cnt++;
        if (exp_we_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got din 0x%0h, required no write", fifo_din);
        end else begin
          check("fifo_din", {24'd0, fifo_din}, {24'd0, exp_we_q.pop_front()});
        end
      end
      if (fifo_re) re_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1, required 0");
        end else begin
          mon_e = exp_done_q.pop_front();
          check("done_flags", {28'd0, flags}, {28'd0, mon_e.flags});
          check("done_err_cnt", {16'd0, err_cnt}, {16'd0, mon_e.err});
          check("done_last_rd_data", {24'd0, last_rd_data}, {24'd0, mon_e.last});
        end
      end
      prev_strobe = fifo_we || fifo_re;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  // Reset pulse; checks every output the cycle after rst, then reloads the model.
  task automatic do_reset(input logic [7:0] s);
    @(negedge clk);
    rst = 1; key_we_n = 1; key_re_n = 1; seed = s;
    @(negedge clk);
    check("rst_fifo_we", {31'd0, fifo_we}, 32'd0);
    check("rst_fifo_re", {31'd0, fifo_re}, 32'd0);
    check("rst_state_dbg", {28'd0, state_dbg}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_last_rd_data", {24'd0, last_rd_data}, 32'd0);
    check("rst_fifo_din", {24'd0, fifo_din}, 32'd0);
    rst = 0;
    exp_we_q.delete(); exp_done_q.delete(); mem.delete(); ref_fifo.delete();
    ref_wr_val = s; ref_exp_val = s; ref_last = '0; ref_err = '0; ref_flags = '0;
    rd_total = 0; ref_rd_total = 0; corrupt_at = -1;
  endtask

  // One burst: predict, press, wait (bounded) for done, hold, release.
  task automatic run_burst(input bit is_read, input bit both, input int len,
                           input bit exp_tmo, output int lat);
    int n, reads, d0;
    logic [7:0] v, r;
    burst_len = len[7:0];
    if (exp_tmo) begin
      ref_flags[3] = 1;
    end else if (!is_read) begin
      if (force_ovf) begin
        ref_flags[0] = 1;
      end else begin
        for (int i = 0; i <= len; i++) begin
          exp_we_q.push_back(ref_wr_val);
          ref_fifo.push_back(ref_wr_val);
          ref_wr_val = ref_wr_val + 8'd1;
        end
      end
    end else begin
      n     = len + 1;
      reads = force_empty ? 0 : ((n < ref_fifo.size()) ? n : ref_fifo.size());
      for (int i = 0; i < reads; i++) begin
        v = ref_fifo.pop_front();
        r = (ref_rd_total == corrupt_at) ? (v ^ 8'h5A) : v;
        ref_rd_total++;
        ref_last = r;
`ifdef FIFO_BURST_CHECK_EN
        if (r != ref_exp_val) begin
          ref_flags[2] = 1;
          if (ref_err != 16'hFFFF) ref_err = ref_err + 16'd1;
        end
        ref_exp_val = ref_exp_val + 8'd1;
`endif
      end
      if (reads < n) ref_flags[1] = 1;
    end
    exp_done_q.push_back('{ref_flags, ref_err, ref_last});
    d0 = done_cnt;
    @(negedge clk);
    if (is_read) key_re_n = 0;
    if (!is_read || both) key_we_n = 0;
    lat = 0;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL burst_timeout: no done after %0d cycles, required done", lat);
      exp_done_q.delete(); exp_we_q.delete();
    end
    repeat (20) @(negedge clk);
    key_we_n = 1; key_re_n = 1;
    repeat (DbCycles + 6) @(negedge clk);
    check("done_count", done_cnt - d0, 32'd1);
    check("writes_pending", exp_we_q.size(), 32'd0);
  endtask

  int lat, we0, re0, d0, n;

  initial begin
    rst = 1; key_we_n = 1; key_re_n = 1; burst_len = '0; seed = '0;
    repeat (2) @(negedge clk);
    do_reset(8'h05);

    // Basic write burst of four words, then read them back.
    run_burst(0, 0, 3, 0, lat);
    run_burst(1, 0, 3, 0, lat);

    // Corrupt the third returned word of the next read burst.
    run_burst(0, 0, 3, 0, lat);
    corrupt_at = ref_rd_total + 2;
    run_burst(1, 0, 3, 0, lat);

    // Bouncing key: no burst may start during the bounce.
    we0 = we_cnt; d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      key_we_n = ~key_we_n;
      repeat (2) @(negedge clk);
    end
    key_we_n = 1;
    repeat (DbCycles + 6) @(negedge clk);
    check("bounce_no_writes", we_cnt - we0, 32'd0);
    check("bounce_no_done", done_cnt - d0, 32'd0);
    run_burst(0, 0, 2, 0, lat);
    check("bounce_burst_writes", we_cnt - we0, 32'd3);

    // Underrun: read with empty forced; done latency = 2 sync + debounce + 3.
    force_empty = 1; re0 = re_cnt;
    run_burst(1, 0, 0, 0, lat);
    check("underrun_done_latency", lat, DbCycles + 5);
    check("underrun_no_reads", re_cnt - re0, 32'd0);
    force_empty = 0;
    repeat (2) @(negedge clk);

    // Both keys together with busy stuck high: read wins, then times out.
    force_busy = 1; we0 = we_cnt; re0 = re_cnt;
    run_burst(1, 1, 2, 1, lat);
    check("both_keys_no_writes", we_cnt - we0, 32'd0);
    check("busy_stuck_no_reads", re_cnt - re0, 32'd0);
    check("timeout_back_to_idle", {28'd0, state_dbg}, 32'd0);
    force_busy = 0;
    repeat (5) @(negedge clk);

    // Overflow aborts a write burst before any strobe.
    force_ovf = 1; we0 = we_cnt;
    run_burst(0, 0, 5, 0, lat);
    check("overflow_no_writes", we_cnt - we0, 32'd0);
    force_ovf = 0;
    repeat (2) @(negedge clk);

    // Randomised bursts against the reference model.
    for (int i = 0; i < 12; i++) begin
      run_burst($urandom_range(0, 1), 0, $urandom_range(0, 5), 0, lat);
    end

    // Data wrap.
    do_reset(8'hFF);
    run_burst(0, 0, 1, 0, lat);

    // Reset in the middle of a long burst.
    burst_len = 8'd255;
    for (int i = 0; i < 256; i++) begin
      exp_we_q.push_back(ref_wr_val);
      ref_wr_val = ref_wr_val + 8'd1;
    end
    we0 = we_cnt; n = 0;
    @(negedge clk);
    key_we_n = 0;
    while ((we_cnt - we0) < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((we_cnt - we0) < 3) begin
      checks++; errors++;
      $display("FAIL midburst_start: got %0d writes, required 3", we_cnt - we0);
    end
    do_reset(8'h20);
    repeat (DbCycles + 6) @(negedge clk);
    check("post_reset_idle", {28'd0, state_dbg}, 32'd0);
    run_burst(0, 0, 0, 0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
